// File: rtl/if_fetch_stage.sv
// if_fetch_stage: owns the PC, fetches words from imem over req/ack and buffers
// {pc, instruction} pairs for decode behind a valid/ready handshake.
// Decode's redirect (pc_src_i) and halt (pc_wre_i == 0) act only when an entry is accepted.
// Optional macro IF_BYPASS_EN: with an empty buffer, an ack in RUN is presented to
// decode in the same cycle. If decode takes it, the entry is never written to the buffer.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_src_i,
    input  logic        pc_wre_i,
    input  logic [31:0] branch_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] instruction_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DROP = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t        state_q, state_n;
    logic [31:0]   fetch_pc_q, fetch_pc_n;
    logic [CW-1:0] count_q, count_n;
    logic          valid_q;
    logic          req_q, req_n;
    logic [31:0]   addr_q, addr_n;

    // Shift-register buffer: entry 0 is always the head shown to decode.
    logic [31:0]   pc_mem_q  [FIFO_DEPTH];
    logic [31:0]   ins_mem_q [FIFO_DEPTH];
    logic [31:0]   pc_mem_n  [FIFO_DEPTH];
    logic [31:0]   ins_mem_n [FIFO_DEPTH];

    logic          ack;
    logic          bypass;
    logic          fire;
    logic          pop;
    logic          push;
    logic          halt_fire;
    logic          redir_fire;
    logic          flush;
    logic [CW-1:0] widx;

    // Handshake decode, next-state and buffer update.
    always_comb begin
        ack        = req_q & imem_ack_i;
`ifdef IF_BYPASS_EN
        bypass     = (state_q == RUN) && (count_q == '0) && ack;
`else
        bypass     = 1'b0;
`endif
        fire       = (valid_q | bypass) & id_ready_i;
        pop        = valid_q & id_ready_i;
        halt_fire  = fire & ~pc_wre_i;
        redir_fire = fire & pc_wre_i & pc_src_i;
        flush      = halt_fire | redir_fire;
        // A bypassed entry taken by decode is never written to the buffer.
        push       = ack && (state_q == RUN) && !(bypass && id_ready_i) && !flush;
        widx       = count_q - CW'(pop);

        pc_mem_n   = pc_mem_q;
        ins_mem_n  = ins_mem_q;
        if (pop) begin
            for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
                pc_mem_n[i]  = pc_mem_q[i + 1];
                ins_mem_n[i] = ins_mem_q[i + 1];
            end
        end
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (push && (widx == CW'(i))) begin
                pc_mem_n[i]  = addr_q;
                ins_mem_n[i] = imem_rdata_i;
            end
        end

        if (flush) begin
            count_n = '0;
        end else begin
            count_n = count_q + CW'(push) - CW'(pop);
        end

        state_n    = state_q;
        fetch_pc_n = fetch_pc_q;
        if (ack && (state_q == RUN)) begin
            fetch_pc_n = fetch_pc_q + 32'd4;
        end
        if ((state_q == DROP) && ack) begin
            state_n = RUN;
        end
        if (redir_fire) begin
            fetch_pc_n = {branch_addr_i[31:2], 2'b00};
            // A request still in flight must be drained before fetching from the target.
            state_n    = (req_q && !ack) ? DROP : RUN;
        end
        if (halt_fire) begin
            state_n = HALT;
        end

        // One request in flight; it is held until acked. Otherwise issue only if the
        // buffer will still have room when the data returns.
        req_n  = 1'b0;
        addr_n = addr_q;
        if (req_q && !ack) begin
            req_n = 1'b1;
        end else if ((state_n == RUN) && (count_n < CW'(FIFO_DEPTH))) begin
            req_n  = 1'b1;
            addr_n = fetch_pc_n;
        end
    end

    // State, PC, request and buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            fetch_pc_q <= {RESET_PC[31:2], 2'b00};
            count_q    <= '0;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                pc_mem_q[i]  <= '0;
                ins_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_n;
            fetch_pc_q <= fetch_pc_n;
            count_q    <= count_n;
            valid_q    <= (count_n != '0);
            req_q      <= req_n;
            addr_q     <= addr_n;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                pc_mem_q[i]  <= pc_mem_n[i];
                ins_mem_q[i] <= ins_mem_n[i];
            end
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;

`ifdef IF_BYPASS_EN
    assign id_valid_o    = valid_q | bypass;
    assign pc_o          = bypass ? addr_q : pc_mem_q[0];
    assign instruction_o = bypass ? imem_rdata_i : ins_mem_q[0];
`else
    assign id_valid_o    = valid_q;
    assign pc_o          = pc_mem_q[0];
    assign instruction_o = ins_mem_q[0];
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC register and issues word fetches to instruction memory over a req/ack handshake.
- Buffers fetched {pc, instruction} pairs in a small FIFO and presents them to decode with a valid/ready handshake.
- Consumes decode's redirect (PCSrc, branch_addr) and halt (PCWre) controls.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, fetch buffer entries; legal values 2 or 4.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset
- pc_src_i  in  1  redirect request from decode; qualified by the decode handshake
- pc_wre_i  in  1  0 = halt request from decode; qualified by the decode handshake
- branch_addr_i  in  32  redirect target
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address; word aligned
- imem_ack_i  in  1  fetch complete; data valid this cycle
- imem_rdata_i  in  32  fetched instruction
- id_valid_o  out  1  pc_o and instruction_o valid
- id_ready_i  in  1  decode accepts the current entry
- pc_o  out  32  PC of the presented instruction
- instruction_o  out  32  presented instruction

Behaviour:
- Reset: rst is synchronous, active-high.
  - Reset values: fetch_pc=RESET_PC, FIFO empty, state=RUN, imem_req_o=0, imem_addr_o=0, id_valid_o=0, pc_o=0, instruction_o=0.
  - A request outstanding when reset asserts is abandoned; imem is reset by the same rst.
- States: RUN, DROP, HALT.
- Issue rule (RUN):
  - imem_req_o=1 with imem_addr_o=fetch_pc when no request is outstanding and count+1 <= FIFO_DEPTH.
  - At most one request outstanding.
  - req and addr are held stable until the ack cycle.
  - Issue is combinational: the new request may go out the cycle after ack.
- Ack in RUN: push {imem_addr_o, imem_rdata_i}; fetch_pc <= fetch_pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
- Output:
  - id_valid_o = FIFO not empty; pc_o/instruction_o = FIFO head.
  - Pop on id_valid_o && id_ready_i.
  - Push and pop in the same cycle are allowed; count unchanged.
  - Ack with FIFO full cannot occur by the issue rule.
- Latency (no bypass): ack in cycle N -> id_valid_o in N+1.
- Redirect fires on id_valid_o && id_ready_i && pc_src_i:
  - FIFO flushed, including any same-cycle push.
  - fetch_pc <= {branch_addr_i[31:2], 2'b00}.
  - If a request is outstanding and not acked this cycle -> DROP.
  - If acked this cycle: data discarded, stay RUN.
- DROP:
  - Keep the old req/addr asserted until ack; discard the data; then -> RUN.
  - The next request uses the redirect PC.
  - id_valid_o=0 throughout.
- Halt fires on id_valid_o && id_ready_i && !pc_wre_i:
  - Flush FIFO -> HALT; has priority over a simultaneous redirect.
  - In HALT: an outstanding request is completed and its data discarded; no new requests; id_valid_o=0.
  - Exit only via rst.
- pc_src_i, pc_wre_i and branch_addr_i are ignored when the handshake does not fire.

Optional Feature:
- IF_BYPASS_EN defined: when the FIFO is empty, state=RUN and imem_ack_i=1:
  - id_valid_o=1 in the same cycle; pc_o=imem_addr_o; instruction_o=imem_rdata_i.
  - If id_ready_i=1, the entry is consumed without a push (0-cycle fetch-to-decode).
  - If id_ready_i=0, it is pushed normally.
  - A redirect/halt fired on a bypassed entry follows the same rules.
- Undefined: all data passes through the FIFO with 1-cycle latency.

Test Plan:
- Reset, then ack every request 1 cycle after issue, id_ready_i=1 -> imem_addr_o sequence 0,4,8,C; pc_o/instruction_o match in order, one cycle after each ack.
- id_ready_i=0 for 6 cycles -> exactly FIFO_DEPTH=2 entries fetched (0,4), imem_req_o=0 while full; on release, 0 then 4 delivered, then fetch resumes at 8.
- Redirect with branch_addr_i=32'h0000_0103 accepted while a request to 8 is outstanding (ack 2 cycles later) -> data for 8 dropped, next imem_addr_o=32'h0000_0100, no stale id_valid_o.
- Redirect and ack in the same cycle -> acked data never presented; next request at the target.
- pc_wre_i=0 accepted at pc_o=C -> id_valid_o=0 and imem_req_o=0 forever after any outstanding ack; rst -> fetch restarts at RESET_PC.
- fetch_pc=32'hFFFF_FFFC fetched -> next imem_addr_o=0; with IF_BYPASS_EN, ack with empty FIFO and ready -> id_valid_o high in the ack cycle.
